// File: rtl/elevator_pkg.sv
// Shared types for the SCAN elevator scheduler: car states, slot status and direction encoding.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_WAITING = 2'd1,
        SLOT_ONBOARD = 2'd2
    } slot_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_slot_table.sv
// Ride-request slot table: free-slot allocation, boarding/alighting updates and the floor target mask.
module elevator_slot_table
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned NUM_SLOTS  = 4,
    localparam int unsigned FLOOR_W   = $clog2(NUM_FLOORS),
    localparam int unsigned ID_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  store,
    input  logic [FLOOR_W-1:0]    store_src,
    input  logic [FLOOR_W-1:0]    store_dest,
    input  logic                  door_active,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic                  free_any,
    output logic [ID_W-1:0]       free_id,
    output logic [NUM_FLOORS-1:0] target_mask,
    output logic                  done_valid,
    output logic [NUM_SLOTS-1:0]  done_mask
);

    slot_e              status_q [NUM_SLOTS];
    logic [FLOOR_W-1:0] src_q    [NUM_SLOTS];
    logic [FLOOR_W-1:0] dest_q   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] alight;

    // Lowest-index free slot wins; scanning downward leaves the lowest one last.
    always_comb begin
        free_any = 1'b0;
        free_id  = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (status_q[i] == SLOT_FREE) begin
                free_any = 1'b1;
                free_id  = ID_W'(i);
            end
        end
    end

    always_comb begin
        target_mask = '0;
        alight      = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (status_q[i] == SLOT_WAITING) begin
                target_mask[src_q[i]] = 1'b1;
            end else if (status_q[i] == SLOT_ONBOARD) begin
                target_mask[dest_q[i]] = 1'b1;
            end
            alight[i] = door_active && (status_q[i] == SLOT_ONBOARD) && (dest_q[i] == cur_floor);
        end
    end

    // Door actions only touch occupied slots, so a same-edge accept never collides with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                status_q[i] <= SLOT_FREE;
                src_q[i]    <= '0;
                dest_q[i]   <= '0;
            end
            done_mask  <= '0;
            done_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (alight[i]) begin
                    status_q[i] <= SLOT_FREE;
                end else if (door_active && (status_q[i] == SLOT_WAITING) && (src_q[i] == cur_floor)) begin
                    status_q[i] <= SLOT_ONBOARD;
                end else if (store && (status_q[i] == SLOT_FREE) && (free_id == ID_W'(i))) begin
                    status_q[i] <= SLOT_WAITING;
                    src_q[i]    <= store_src;
                    dest_q[i]   <= store_dest;
                end
            end
            done_mask  <= alight;
            done_valid <= |alight;
        end
    end

endmodule

// File: rtl/elevator_scan_scheduler.sv
// SCAN elevator scheduler: request handshake, car FSM with move/door timers, floor and direction tracking.
module elevator_scan_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS  = 8,
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned MOVE_CYCLES = 10,
    parameter int unsigned DOOR_CYCLES = 30,
    localparam int unsigned FLOOR_W    = $clog2(NUM_FLOORS),
    localparam int unsigned ID_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [FLOOR_W-1:0]   req_src,
    input  logic [FLOOR_W-1:0]   req_dest,
    output logic                 req_ready,
    output logic [ID_W-1:0]      req_id,
    output logic                 req_err,
    output logic                 done_valid,
    output logic [NUM_SLOTS-1:0] done_mask,
    output logic [FLOOR_W-1:0]   ev_floor,
    output logic                 ev_dir,
    output logic                 ev_moving,
    output logic                 ev_door
);

    localparam int unsigned TIMER_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [FLOOR_W:0] FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

    state_e                state_q, state_d;
    logic                  dir_d;
    logic [FLOOR_W-1:0]    floor_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [NUM_FLOORS-1:0] target_mask;
    logic                  accept, bad_req, above, below, here;

    assign accept  = req_valid && req_ready;
    assign bad_req = (req_src == req_dest) || ({1'b0, req_src} >= FLOOR_LIMIT)
                     || ({1'b0, req_dest} >= FLOOR_LIMIT);

    elevator_slot_table #(
        .NUM_FLOORS (NUM_FLOORS),
        .NUM_SLOTS  (NUM_SLOTS)
    ) u_slots (
        .clk         (clk),
        .rst         (rst),
        .store       (accept && !bad_req),
        .store_src   (req_src),
        .store_dest  (req_dest),
        .door_active (state_q == ST_DOOR),
        .cur_floor   (ev_floor),
        .free_any    (req_ready),
        .free_id     (req_id),
        .target_mask (target_mask),
        .done_valid  (done_valid),
        .done_mask   (done_mask)
    );

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int f = 0; f < NUM_FLOORS; f++) begin
            if (target_mask[f] && (FLOOR_W'(f) > ev_floor)) above = 1'b1;
            if (target_mask[f] && (FLOOR_W'(f) < ev_floor)) below = 1'b1;
        end
        here = target_mask[ev_floor];
    end

    // Next-state: keep heading while targets lie ahead, reverse only from IDLE.
    always_comb begin
        state_d = state_q;
        dir_d   = ev_dir;
        floor_d = ev_floor;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (here) begin
                    state_d = ST_DOOR;
                end else if (ev_dir == DIR_UP) begin
                    if (above) begin
                        state_d = ST_MOVE;
                    end else if (below) begin
                        dir_d   = DIR_DOWN;
                        state_d = ST_MOVE;
                    end
                end else begin
                    if (below) begin
                        state_d = ST_MOVE;
                    end else if (above) begin
                        dir_d   = DIR_UP;
                        state_d = ST_MOVE;
                    end
                end
            end
            ST_MOVE: begin
                if (timer_q == TIMER_W'(MOVE_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    floor_d = (ev_dir == DIR_UP) ? ev_floor + FLOOR_W'(1) : ev_floor - FLOOR_W'(1);
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_DOOR: begin
                if (timer_q == TIMER_W'(DOOR_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            ev_floor  <= '0;
            ev_dir    <= DIR_UP;
            ev_moving <= 1'b0;
            ev_door   <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ev_floor  <= floor_d;
            ev_dir    <= dir_d;
            ev_moving <= (state_d == ST_MOVE);
            ev_door   <= (state_d == ST_DOOR);
            req_err   <= accept && bad_req;
        end
    end

endmodule

// File: tb/tb_elevator_scan_scheduler.sv
// Self-checking bench for elevator_scan_scheduler: ride-level reference model plus directed scenarios.
module tb_elevator_scan_scheduler;

    localparam int NF = 8;
    localparam int NS = 4;
    localparam int MC = 10;
    localparam int DC = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_src = '0;
    logic [2:0] req_dest = '0;
    logic       req_ready, req_err, done_valid, ev_dir, ev_moving, ev_door;
    logic [1:0] req_id;
    logic [3:0] done_mask;
    logic [2:0] ev_floor;

    // Second instance with six floors so an out-of-range floor index is representable.
    logic       b_valid = 1'b0;
    logic [2:0] b_src = '0;
    logic [2:0] b_dest = '0;
    logic       b_ready, b_err, b_done_valid, b_dir, b_moving, b_door;
    logic [1:0] b_id;
    logic [3:0] b_done_mask;
    logic [2:0] b_floor;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    elevator_scan_scheduler #(.NUM_FLOORS(NF), .NUM_SLOTS(NS), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_src(req_src), .req_dest(req_dest),
        .req_ready(req_ready), .req_id(req_id), .req_err(req_err), .done_valid(done_valid),
        .done_mask(done_mask), .ev_floor(ev_floor), .ev_dir(ev_dir), .ev_moving(ev_moving), .ev_door(ev_door)
    );

    elevator_scan_scheduler #(.NUM_FLOORS(6), .NUM_SLOTS(NS), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut6 (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_src(b_src), .req_dest(b_dest),
        .req_ready(b_ready), .req_id(b_id), .req_err(b_err), .done_valid(b_done_valid),
        .done_mask(b_done_mask), .ev_floor(b_floor), .ev_dir(b_dir), .ev_moving(b_moving), .ev_door(b_door)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Ride-level model: phase 0 idle, 1 travelling, 2 door open; slot kind 0 free, 1 waiting, 2 riding.
    int m_floor, m_dir, m_phase, m_left, m_err, m_done;
    int m_kind [NS];
    int m_src  [NS];
    int m_dst  [NS];
    bit model_on = 1'b0;

    function automatic int m_first_free();
        for (int i = 0; i < NS; i++) if (m_kind[i] == 0) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_dir = 1; m_phase = 0; m_left = 0; m_err = 0; m_done = 0;
        for (int i = 0; i < NS; i++) begin m_kind[i] = 0; m_src[i] = 0; m_dst[i] = 0; end
    endtask

    task automatic model_step(input bit v, input int s, input int d);
        bit want [NF];
        int nk [NS];
        int slot, dm;
        bit bad, ahead, behind;
        slot = m_first_free();
        bad = (s == d) || (s >= NF) || (d >= NF);
        for (int f = 0; f < NF; f++) want[f] = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (m_kind[i] == 1) want[m_src[i]] = 1'b1;
            if (m_kind[i] == 2) want[m_dst[i]] = 1'b1;
        end
        dm = 0;
        for (int i = 0; i < NS; i++) begin
            nk[i] = m_kind[i];
            if (m_phase == 2 && m_kind[i] == 2 && m_dst[i] == m_floor) begin
                nk[i] = 0;
                dm |= (1 << i);
            end else if (m_phase == 2 && m_kind[i] == 1 && m_src[i] == m_floor) begin
                nk[i] = 2;
            end
        end
        m_err = (v && slot >= 0 && bad) ? 1 : 0;
        if (v && slot >= 0 && !bad) begin
            nk[slot] = 1; m_src[slot] = s; m_dst[slot] = d;
        end
        m_done = dm;
        ahead = 1'b0; behind = 1'b0;
        for (int f = 0; f < NF; f++) begin
            if (want[f] && ((m_dir == 1 && f > m_floor) || (m_dir == 0 && f < m_floor))) ahead = 1'b1;
            else if (want[f] && f != m_floor) behind = 1'b1;
        end
        case (m_phase)
            0: begin
                if (want[m_floor]) begin m_phase = 2; m_left = DC; end
                else if (ahead) begin m_phase = 1; m_left = MC; end
                else if (behind) begin m_dir = 1 - m_dir; m_phase = 1; m_left = MC; end
            end
            1: begin
                m_left--;
                if (m_left == 0) begin m_floor += (m_dir == 1) ? 1 : -1; m_phase = 0; end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_phase = 0;
            end
        endcase
        for (int i = 0; i < NS; i++) m_kind[i] = nk[i];
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step(req_valid, int'(req_src), int'(req_dest));
    end

    // Per-cycle comparison plus event logs of door openings, alight masks and direction flips.
    int door_q [$];
    int done_q [$];
    int dir_flips = 0;
    int flip_floor = -1;
    logic prev_door = 1'b0;
    logic prev_dir = 1'b1;

    always @(negedge clk) begin
        if (model_on) begin
            chk("ev_floor", int'(ev_floor), m_floor);
            chk("ev_dir", int'(ev_dir), m_dir);
            chk("ev_moving", int'(ev_moving), (m_phase == 1) ? 1 : 0);
            chk("ev_door", int'(ev_door), (m_phase == 2) ? 1 : 0);
            chk("req_ready", int'(req_ready), (m_first_free() >= 0) ? 1 : 0);
            if (m_first_free() >= 0) chk("req_id", int'(req_id), m_first_free());
            chk("req_err", int'(req_err), m_err);
            chk("done_valid", int'(done_valid), (m_done != 0) ? 1 : 0);
            chk("done_mask", int'(done_mask), m_done);
            if (ev_door && !prev_door) door_q.push_back(int'(ev_floor));
            if (done_valid) done_q.push_back(int'(done_mask));
            if (ev_dir != prev_dir) begin dir_flips++; flip_floor = int'(ev_floor); end
        end
        prev_door = ev_door;
        prev_dir  = ev_dir;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        door_q.delete();
        done_q.delete();
        dir_flips = 0;
        flip_floor = -1;
    endtask

    task automatic send(input int s, input int d, input int budget, output int id);
        bit got;
        got = 1'b0;
        id = -1;
        req_valid = 1'b1;
        req_src = 3'(s);
        req_dest = 3'(d);
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (req_ready) begin id = int'(req_id); got = 1'b1; end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_quiet(input int budget);
        bit quiet;
        quiet = 1'b0;
        for (int c = 0; c < budget && !quiet; c++) begin
            @(negedge clk);
            quiet = !ev_moving && !ev_door && m_phase == 0 && m_first_free() == 0
                    && m_kind[1] == 0 && m_kind[2] == 0 && m_kind[3] == 0;
        end
        if (!quiet) chk("quiet_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_floor(input int f, input bit need_move, input int budget);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < budget && !hit; c++) begin
            @(negedge clk);
            hit = (int'(ev_floor) == f) && (!need_move || ev_moving);
        end
        if (!hit) chk("floor_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic cmp_q(input string name, input int act[$], input int exp[$]);
        chk({name, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size() && i < act.size(); i++) chk(name, act[i], exp[i]);
    endtask

    initial begin
        int id, id2;
        int exp_q [$];
        #2 rst = 1'b1;
        #1 model_on = 1'b1;
        @(negedge clk);
        chk("rst_outputs", int'({ev_floor, ev_dir, ev_moving, ev_door, req_err, done_valid, done_mask}), 32'h100);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_b_ready", int'(b_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single ride 2 -> 5.
        send(2, 5, 10, id);
        chk("t1_id", id, 0);
        wait_quiet(600);
        exp_q = '{2, 5};
        cmp_q("t1_doors", door_q, exp_q);
        exp_q = '{1};
        cmp_q("t1_done", done_q, exp_q);
        chk("t1_floor", int'(ev_floor), 5);

        // Two upward rides collected in one sweep.
        do_reset();
        send(3, 6, 10, id);
        send(4, 7, 10, id2);
        chk("t2_id0", id, 0);
        chk("t2_id1", id2, 1);
        wait_quiet(1000);
        exp_q = '{3, 4, 6, 7};
        cmp_q("t2_doors", door_q, exp_q);
        exp_q = '{1, 2};
        cmp_q("t2_done", done_q, exp_q);
        chk("t2_flips", dir_flips, 0);

        // Down request arriving mid-sweep is served only after the upward target.
        do_reset();
        send(0, 6, 10, id);
        wait_floor(4, 1'b0, 500);
        send(2, 1, 10, id);
        wait_quiet(1500);
        exp_q = '{0, 6, 2, 1};
        cmp_q("t3_doors", door_q, exp_q);
        chk("t3_flips", dir_flips, 1);
        chk("t3_flip_floor", flip_floor, 6);

        // Rejected requests consume no slot.
        do_reset();
        send(3, 3, 10, id);
        chk("t4_err_pulse", int'(req_err), 1);
        tick(1);
        chk("t4_err_clear", int'(req_err), 0);
        chk("t4_ready", int'(req_ready), 1);
        chk("t4_id", int'(req_id), 0);
        b_valid = 1'b1; b_src = 3'd6; b_dest = 3'd1;
        tick(1);
        b_valid = 1'b0;
        chk("t4_b_err_src", int'(b_err), 1);
        b_valid = 1'b1; b_src = 3'd2; b_dest = 3'd7;
        tick(1);
        b_valid = 1'b0;
        chk("t4_b_err_dest", int'(b_err), 1);
        tick(1);
        chk("t4_b_err_clear", int'(b_err), 0);
        chk("t4_b_slots", int'({b_ready, b_id}), 4);
        chk("t4_b_status", int'({b_dir, b_moving, b_door, b_done_valid, b_done_mask, b_floor}), 1024);
        b_valid = 1'b1; b_src = 3'd2; b_dest = 3'd3;
        tick(1);
        b_valid = 1'b0;
        chk("t4_b_good", int'({b_err, b_id}), 1);

        // Table full: a held fifth request takes the first slot that frees.
        do_reset();
        send(1, 2, 10, id);  chk("t5_id0", id, 0);
        send(3, 4, 10, id);  chk("t5_id1", id, 1);
        send(5, 6, 10, id);  chk("t5_id2", id, 2);
        send(6, 7, 10, id);  chk("t5_id3", id, 3);
        chk("t5_full", int'(req_ready), 0);
        send(7, 0, 1000, id);
        chk("t5_id4", id, 0);
        wait_quiet(3000);
        exp_q = '{1, 2, 3, 4, 5, 6, 7, 0};
        cmp_q("t5_doors", door_q, exp_q);
        exp_q = '{1, 2, 4, 8, 1};
        cmp_q("t5_done", done_q, exp_q);

        // Reset while travelling between floors 2 and 3.
        do_reset();
        send(5, 6, 10, id);
        wait_floor(2, 1'b1, 500);
        tick(3);
        rst = 1'b1;
        #1;
        chk("t6_rst_state", int'({ev_floor, ev_door, ev_moving, req_ready, ev_dir}), 3);
        @(posedge clk); #1;
        rst = 1'b0;
        done_q.delete();
        tick(100);
        chk("t6_no_done", done_q.size(), 0);
        chk("t6_idle", int'({ev_moving, ev_door}), 0);

        // Request at the idle car's floor: door opens on the second edge after it is offered.
        do_reset();
        req_valid = 1'b1; req_src = 3'd0; req_dest = 3'd1;
        tick(1);
        req_valid = 1'b0;
        chk("t7_door_early", int'(ev_door), 0);
        tick(1);
        chk("t7_door_open", int'(ev_door), 1);
        wait_quiet(300);
        chk("t7_floor", int'(ev_floor), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/elevator_scan_scheduler.md
Name: elevator_scan_scheduler

Overview:
- Parametrised successor of the two-passenger controller.
- Accepts up to NUM_SLOTS concurrent ride requests (src, dest) through a valid/ready handshake, holding each in a slot table.
- Drives an internal car model (floor register, move timer, door timer) using a SCAN (collective) policy: keep direction while any target lies ahead, otherwise reverse.
- Fully synchronous replacement for the delay-based target/elevator pair; sits between the hall/cab request front-end and the display/status logic.

Parameters:
- NUM_FLOORS, 8: floors 0..NUM_FLOORS-1. Must be >= 2.
- NUM_SLOTS, 4: concurrent requests held. Must be >= 1.
- MOVE_CYCLES, 10: clk cycles to travel one floor. Must be >= 1.
- DOOR_CYCLES, 30: clk cycles the door stays open per stop. Must be >= 1.
- FLOOR_W, $clog2(NUM_FLOORS): floor index width (derived).
- ID_W, max(1,$clog2(NUM_SLOTS)): slot index width (derived).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request offered
- req_src  in  FLOOR_W  pickup floor
- req_dest  in  FLOOR_W  drop-off floor
- req_ready  out  1  a free slot exists
- req_id  out  ID_W  slot assigned to the current handshake (valid when req_valid&req_ready)
- req_err  out  1  one-cycle pulse: request rejected
- done_valid  out  1  one-cycle pulse: a passenger alighted
- done_mask  out  NUM_SLOTS  slots completed this cycle
- ev_floor  out  FLOOR_W  current car floor
- ev_dir  out  1  1=up, 0=down
- ev_moving  out  1  high in MOVE
- ev_door  out  1  high in DOOR

Behaviour:
- Reset values: ev_floor=0, ev_dir=1, all slots FREE, state IDLE, timers 0. All outputs low except ev_dir=1 and req_ready=1. Reset mid-move or mid-door abandons all requests; no done pulses are issued.
- Slot status: FREE, WAITING, ONBOARD. Per-slot src/dest are registered.
- Handshake:
  - req_ready = any slot FREE, computed from registered state only. Slots freed this cycle become visible next cycle.
  - req_id = lowest-index FREE slot.
  - Accept on req_valid&req_ready. The slot becomes WAITING at the next edge.
  - Reject when src==dest or either floor >= NUM_FLOORS: req_err pulses the next cycle, nothing is stored, and the handshake still completes.
  - When no slot is free, the requester holds req_valid.
- Target mask (NUM_FLOORS bits) = OR of src of WAITING slots and dest of ONBOARD slots. above = any mask bit > ev_floor; below = any mask bit < ev_floor; here = mask[ev_floor].
- FSM:
  - IDLE, mask empty: stay.
  - IDLE, here: go to DOOR.
  - IDLE, ev_dir=up & above: go to MOVE up.
  - IDLE, ev_dir=up & !above & below: set ev_dir=0, go to MOVE down. Down direction is symmetric.
  - MOVE: the timer counts MOVE_CYCLES. On the expiry edge ev_floor changes by ±1 and the state returns to IDLE, which re-evaluates the next cycle. Floor never leaves 0..NUM_FLOORS-1, because a target always exists in the direction of travel.
  - DOOR: the timer counts DOOR_CYCLES, then returns to IDLE.
- DOOR actions, every DOOR cycle at ev_floor:
  - ONBOARD slots with dest==ev_floor become FREE and set their done_mask bit. done_valid pulses the cycle after the transition.
  - WAITING slots with src==ev_floor become ONBOARD.
  - Both actions happen in the same edge. A boarder never alights at its own src.
- Requests accepted during DOOR with src==ev_floor board before the door closes.
- Requests accepted during MOVE are considered at the next IDLE evaluation. Direction is never reversed mid-floor.
- Simultaneous accept and alight: legal. They use different slots, because the accept slot was FREE in registered state.
- Direction is derived from src/dest; there is no direction input.
- Latency: accept at edge t. With the car idle at src, ev_door rises at t+2.

Decomposition:
- elevator_pkg:
  - state enum (IDLE, MOVE, DOOR)
  - slot status enum (FREE, WAITING, ONBOARD)
  - DIR_UP/DIR_DOWN constants
- Sub-module elevator_slot_table:
  - holds NUM_SLOTS slots
  - performs free-slot priority encode, accept, board and alight updates
  - outputs the target mask and done_mask
- Top level keeps the FSM, timers, floor and direction.

Test Plan:
- Reset, then request src=2 dest=5 (MOVE_CYCLES=10, DOOR_CYCLES=30) -> car moves up; ev_door opens at floor 2 then floor 5; one done pulse with done_mask=0001; ev_floor=5; IDLE.
- Car at 0; requests (3→6) and (4→7) accepted back to back -> stops in order 3, 4, 6, 7 with no reversal; done at 6 (slot0) and 7 (slot1).
- Car moving up toward 6, then request (2→1) arrives while at floor 4 -> continues to 6, reverses, stops at 2 then 1; ev_dir toggles only at floor 6.
- Requests src=dest=3 and src=NUM_FLOORS -> req_err pulses once each; no slot consumed; req_ready stays 1.
- Fill all 4 slots -> req_ready=0 and a held 5th request waits; after the first alight, req_ready rises the next cycle and the 5th gets the freed id.
- Assert rst mid-MOVE between floors 2 and 3 -> ev_floor=0, ev_door=0, ev_moving=0, req_ready=1, no done pulse afterwards.
